fa_bist_checker: RTL

FA_BIST_CHECKER -- requirements
Module: fa_bist_checker

---
 rtl/fa_bist_checker.sv | 115 +++++++++++
 1 files changed

// File: rtl/fa_bist_checker.sv
// fa_bist_checker
//   Built-in self-test sequencer for a single full adder. On an accepted
//   start it walks the eight input vectors 000..111 across {a, b, c_in},
//   holds each one for SETTLE wait cycles plus one check cycle, compares the
//   adder's sum/carry against the reference, and reports a pass/fail summary.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      run one full pass; only looked at while idle
//   a,b,c_in   registered stimulus to the adder under test
//   sum,carry  adder response, compared unregistered on the check cycle
//   busy       high during the wait/check phases of a pass
//   done       one-cycle pulse when the pass completes
//   pass       last completed pass had no mismatches
//   err_count  mismatching vectors in the current/last pass (0..8)
//   fail_vec   bit i set when vector i mismatched
module fa_bist_checker #(
    parameter int SETTLE = 2        // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c_in,
    input  logic       sum,
    input  logic       carry,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

    // Counter is loaded with SETTLE-1 and the WAIT->CHECK move happens on
    // the edge that sees zero, so WAIT lasts exactly SETTLE cycles.
    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;

    logic sum_exp;
    logic carry_exp;
    logic mismatch;

    // Reference is taken from the registered stimulus, which always equals idx.
    assign sum_exp   = a ^ b ^ c_in;
    assign carry_exp = (a & b) | (a & c_in) | (b & c_in);
    assign mismatch  = (sum != sum_exp) || (carry != carry_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            c_in      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx            <= '0;
                        {a, b, c_in}   <= 3'b000;
                        err_count      <= '0;
                        fail_vec       <= '0;
                        pass           <= 1'b0;
                        cnt            <= RELOAD;
                        busy           <= 1'b1;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= CHECK;
                    else             cnt   <= cnt - 4'd1;
                end
                CHECK: begin
                    // At most one increment per vector, so the count tops out at 8.
                    if (mismatch) begin
                        err_count     <= err_count + 4'd1;
                        fail_vec[idx] <= 1'b1;
                    end
                    if (idx != 3'd7) begin
                        idx          <= idx + 3'd1;
                        {a, b, c_in} <= idx + 3'd1;
                        cnt          <= RELOAD;
                        state        <= WAIT;
                    end else begin
                        // Stimulus stays at 111 until the next start.
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // err_count already includes vector 7 here.
                    done  <= 1'b0;
                    pass  <= (err_count == 4'd0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
